// File: rtl/mips_pkg.sv
// Shared MIPS-side definitions: loader FSM states and widths used by the boot loader.
package mips_pkg;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int LD_COUNT_BYTES = 2;

  typedef enum logic [2:0] {
    LD_HDR,
    LD_PAYLOAD,
    LD_WRITE,
    LD_CHK,
    LD_DONE,
    LD_ERR
  } ld_state_t;
endpackage

// File: rtl/ld_word_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first, flags the 4th byte.
module ld_word_assembler #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [7:0]            byte_in,
  output logic                  word_full,
  output logic [DATA_WIDTH-1:0] word
);
  logic [DATA_WIDTH-9:0] sr;
  logic [1:0]            cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (en) begin
      sr  <= {sr[DATA_WIDTH-17:0], byte_in};
      cnt <= cnt + 2'd1;
    end
  end

  // The completed word includes the byte being accepted this cycle.
  assign word_full = en && (cnt == 2'd3);
  assign word      = {sr, byte_in};
endmodule

// File: rtl/instr_loader.sv
// Boot-time instruction loader: byte stream -> 32-bit words -> instruction memory.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and CHK state.
module instr_loader
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int INSTR_MEM_DEPTH = 4096,
  parameter int ADDR_WIDTH      = $clog2(INSTR_MEM_DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            BYTE_IN,
  input  logic                  BYTE_VALID,
  output logic                  BYTE_READY,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  output logic                  CPU_HOLD,
  output logic [15:0]           WORD_COUNT,
  output logic                  DONE,
  output logic                  ERR
);
  localparam logic [31:0] DEPTH_U = INSTR_MEM_DEPTH[31:0];

  ld_state_t             state, state_next;
  logic                  accept;
  logic                  hdr_cnt;
  logic [7:0]            hdr_hi;
  logic [15:0]           hdr_val;
  logic [15:0]           n;
  logic                  word_full;
  logic [DATA_WIDTH-1:0] word;
  ld_state_t             st_end;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xsum;
  assign BYTE_READY = !RST && (state == LD_HDR || state == LD_PAYLOAD || state == LD_CHK);
  assign st_end     = LD_CHK;
`else
  assign BYTE_READY = !RST && (state == LD_HDR || state == LD_PAYLOAD);
  assign st_end     = LD_DONE;
`endif

  assign accept  = BYTE_READY && BYTE_VALID;
  assign hdr_val = {hdr_hi, BYTE_IN};

  ld_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clk       (CLK),
    .rst       (RST),
    .en        (accept && state == LD_PAYLOAD),
    .byte_in   (BYTE_IN),
    .word_full (word_full),
    .word      (word)
  );

  always_comb begin
    state_next = state;
    case (state)
      LD_HDR:
        if (accept && hdr_cnt == 1'(LD_COUNT_BYTES - 1)) begin
          if (hdr_val == 16'd0)                 state_next = st_end;
          else if ({16'd0, hdr_val} > DEPTH_U)  state_next = LD_ERR;
          else                                  state_next = LD_PAYLOAD;
        end
      LD_PAYLOAD:
        if (word_full) state_next = LD_WRITE;
      LD_WRITE:
        state_next = (WORD_COUNT + 16'd1 == n) ? st_end : LD_PAYLOAD;
`ifdef LOADER_CHECKSUM_EN
      LD_CHK:
        if (accept) state_next = (BYTE_IN == xsum) ? LD_DONE : LD_ERR;
`endif
      default: state_next = state;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= LD_HDR;
      hdr_cnt    <= 1'b0;
      hdr_hi     <= '0;
      n          <= '0;
      WORD_COUNT <= '0;
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      CPU_HOLD   <= 1'b1;
    end else begin
      state <= state_next;
      if (accept && state == LD_HDR) begin
        hdr_cnt <= ~hdr_cnt;
        if (hdr_cnt == 1'b0) hdr_hi <= BYTE_IN;
        else                 n      <= hdr_val;
      end
      // Address is the pre-increment count, so the first word lands at 0.
      if (word_full) begin
        MEM_ADDR  <= WORD_COUNT[ADDR_WIDTH-1:0];
        MEM_WDATA <= word;
      end
      if (state == LD_WRITE) WORD_COUNT <= WORD_COUNT + 16'd1;
      MEM_WE   <= (state_next == LD_WRITE);
      DONE     <= (state_next == LD_DONE);
      ERR      <= (state_next == LD_ERR);
      CPU_HOLD <= (state_next != LD_DONE);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              xsum <= '0;
    else if (accept && state == LD_PAYLOAD) xsum <= xsum ^ BYTE_IN;
  end
`endif
endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: random images checked against a byte-stream model.
module tb_instr_loader;
  localparam int DEPTH = 4096;
  localparam int AW    = $clog2(DEPTH);

  logic          CLK = 1'b0;
  logic          RST;
  logic [7:0]    BYTE_IN;
  logic          BYTE_VALID;
  logic          BYTE_READY;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [31:0]   MEM_WDATA;
  logic          CPU_HOLD;
  logic [15:0]   WORD_COUNT;
  logic          DONE;
  logic          ERR;

  instr_loader #(.DATA_WIDTH(32), .INSTR_MEM_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .CPU_HOLD(CPU_HOLD), .WORD_COUNT(WORD_COUNT),
    .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int inv_viol = 0;
  int done_cyc = -1;

  logic [AW-1:0] log_addr[$];
  logic [31:0]   log_data[$];
  int            log_cyc[$];
  logic          written[DEPTH];
  logic [31:0]   mem_model[DEPTH];

  logic [7:0]    stream_q[$];
  logic [31:0]   exp_words[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory and write log as the core's instruction RAM would see them.
  always @(posedge CLK) if (!RST && MEM_WE) begin
    mem_model[MEM_ADDR] <= MEM_WDATA;
    written[MEM_ADDR]   <= 1'b1;
  end

  always @(negedge CLK) begin
    if (!RST && MEM_WE) begin
      log_addr.push_back(MEM_ADDR);
      log_data.push_back(MEM_WDATA);
      log_cyc.push_back(cyc);
    end
    if (!RST && DONE && done_cyc < 0) done_cyc = cyc;
    // Outside terminal states the loader is ready exactly when not writing.
    if (!RST && !DONE && !ERR && (BYTE_READY !== !MEM_WE)) inv_viol++;
  end

  task automatic clear_log();
    log_addr = {}; log_data = {}; log_cyc = {};
    done_cyc = -1;
    inv_viol = 0;
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1; BYTE_VALID = 1'b0; BYTE_IN = 8'h00;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    clear_log();
  endtask

  // Image model: 16-bit count, words MSB first, optional XOR of payload bytes.
  task automatic make_stream();
    logic [7:0]  cs;
    logic [15:0] n;
    cs = 8'h00;
    n  = 16'(exp_words.size());
    stream_q = {};
    stream_q.push_back(n[15:8]);
    stream_q.push_back(n[7:0]);
    foreach (exp_words[i])
      for (int b = 3; b >= 0; b--) begin
        stream_q.push_back(8'((exp_words[i] >> (8 * b)) & 32'hFF));
        cs = cs ^ 8'((exp_words[i] >> (8 * b)) & 32'hFF);
      end
`ifdef LOADER_CHECKSUM_EN
    stream_q.push_back(cs);
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int waited;
    if (gap_max > 0)
      repeat ($urandom_range(0, gap_max)) begin
        @(negedge CLK);
        BYTE_VALID = 1'b0;
      end
    @(negedge CLK);
    BYTE_IN = b; BYTE_VALID = 1'b1;
    waited = 0;
    while (!BYTE_READY && waited < 200) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 200) begin
      total++; bad++;
      $display("FAIL send_byte timeout: ready stayed %0b, required 1", BYTE_READY);
    end
    @(posedge CLK);
  endtask

  task automatic send_stream(input int gap_max);
    foreach (stream_q[i]) send_byte(stream_q[i], gap_max);
    @(negedge CLK);
    BYTE_VALID = 1'b0;
  endtask

  task automatic wait_end();
    int w;
    w = 0;
    while (!DONE && !ERR && w < 50) begin
      @(negedge CLK);
      w++;
    end
    repeat (2) @(negedge CLK);
  endtask

  task automatic check_image(input string tag);
    total++;
    if (log_addr.size() !== exp_words.size()) begin
      bad++;
      $display("FAIL %s write_count: got %0d, required %0d", tag, log_addr.size(), exp_words.size());
    end
    for (int i = 0; i < exp_words.size() && i < log_addr.size(); i++) begin
      total++;
      if (log_addr[i] !== AW'(i) || log_data[i] !== exp_words[i]) begin
        bad++;
        $display("FAIL %s word%0d: got addr=%0d data=%08h, required addr=%0d data=%08h",
                 tag, i, log_addr[i], log_data[i], i, exp_words[i]);
      end
    end
    total++;
    if (DONE !== 1'b1 || CPU_HOLD !== 1'b0 || ERR !== 1'b0 || WORD_COUNT !== 16'(exp_words.size())) begin
      bad++;
      $display("FAIL %s final: got done=%0b hold=%0b err=%0b wc=%0d, required 1 0 0 %0d",
               tag, DONE, CPU_HOLD, ERR, WORD_COUNT, exp_words.size());
    end
    total++;
    if (inv_viol !== 0) begin
      bad++;
      $display("FAIL %s ready_vs_write: got %0d violations, required 0", tag, inv_viol);
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b1;
    #1;
    total++;
    if (BYTE_READY !== 1'b0 || CPU_HOLD !== 1'b1 || DONE !== 1'b0 || ERR !== 1'b0 ||
        MEM_WE !== 1'b0 || WORD_COUNT !== 16'd0 || MEM_ADDR !== '0 || MEM_WDATA !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: got rdy=%0b hold=%0b done=%0b err=%0b we=%0b wc=%0d addr=%0d wd=%08h, required 0 1 0 0 0 0 0 0",
               BYTE_READY, CPU_HOLD, DONE, ERR, MEM_WE, WORD_COUNT, MEM_ADDR, MEM_WDATA);
    end
    @(negedge CLK);
    RST = 1'b0;
    clear_log();
    @(negedge CLK);
    total++;
    if (BYTE_READY !== 1'b1 || CPU_HOLD !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: got rdy=%0b hold=%0b, required 1 1", BYTE_READY, CPU_HOLD);
    end
  endtask

  task automatic test_basic();
    do_reset();
    exp_words = {32'h20100005, 32'h02114020};
    make_stream();
    send_stream(0);
    wait_end();
    check_image("basic");
`ifndef LOADER_CHECKSUM_EN
    total++;
    if (log_cyc.size() != 2 || done_cyc != log_cyc[1] + 1) begin
      bad++;
      $display("FAIL basic done_timing: got done_cyc=%0d, required last_write+1", done_cyc);
    end
`endif
  endtask

  task automatic test_zero();
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h00, 0);
`endif
    @(negedge CLK);
    BYTE_VALID = 1'b0;
    total++;
    if (DONE !== 1'b1 || CPU_HOLD !== 1'b0) begin
      bad++;
      $display("FAIL zero_done: got done=%0b hold=%0b, required 1 0", DONE, CPU_HOLD);
    end
    repeat (3) @(negedge CLK);
    total++;
    if (log_addr.size() !== 0 || WORD_COUNT !== 16'd0) begin
      bad++;
      $display("FAIL zero_writes: got %0d writes wc=%0d, required 0 0", log_addr.size(), WORD_COUNT);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_byte(8'h10, 0);
    send_byte(8'h01, 0);
    @(negedge CLK);
    BYTE_VALID = 1'b0;
    total++;
    if (ERR !== 1'b1 || CPU_HOLD !== 1'b1 || BYTE_READY !== 1'b0 || DONE !== 1'b0) begin
      bad++;
      $display("FAIL overflow: got err=%0b hold=%0b rdy=%0b done=%0b, required 1 1 0 0",
               ERR, CPU_HOLD, BYTE_READY, DONE);
    end
    // Extra bytes must be ignored in the terminal state.
    BYTE_IN = 8'hAA; BYTE_VALID = 1'b1;
    repeat (5) @(negedge CLK);
    BYTE_VALID = 1'b0;
    total++;
    if (log_addr.size() !== 0 || ERR !== 1'b1) begin
      bad++;
      $display("FAIL overflow_sticky: got %0d writes err=%0b, required 0 1", log_addr.size(), ERR);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    exp_words = {};
    for (int i = 0; i < 3; i++) exp_words.push_back($urandom);
    make_stream();
    send_stream(3);
    wait_end();
    check_image("gaps");
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      exp_words = {};
      repeat ($urandom_range(1, 8)) exp_words.push_back($urandom);
      make_stream();
      send_stream(r);
      wait_end();
      check_image("random");
    end
  endtask

  task automatic test_abort();
    logic [31:0] w0;
    do_reset();
    exp_words = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    make_stream();
    for (int i = 0; i < 8; i++) send_byte(stream_q[i], 0);
    @(negedge CLK);
    BYTE_VALID = 1'b0;
    RST = 1'b1;
    #1;
    total++;
    if (BYTE_READY !== 1'b0 || WORD_COUNT !== 16'd0 || CPU_HOLD !== 1'b1) begin
      bad++;
      $display("FAIL abort_reset: got rdy=%0b wc=%0d hold=%0b, required 0 0 1", BYTE_READY, WORD_COUNT, CPU_HOLD);
    end
    @(negedge CLK);
    RST = 1'b0;
    w0 = $urandom;
    exp_words = {w0};
    make_stream();
    send_stream(1);
    wait_end();
    total++;
    if (mem_model[0] !== w0 || WORD_COUNT !== 16'd1 || DONE !== 1'b1 || written[1] !== 1'b0) begin
      bad++;
      $display("FAIL abort_reload: got mem0=%08h wc=%0d done=%0b wr1=%0b, required %08h 1 1 0",
               mem_model[0], WORD_COUNT, DONE, written[1], w0);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] img[7];
    img = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    do_reset();
    foreach (img[i]) send_byte(img[i], 0);
    @(negedge CLK);
    BYTE_VALID = 1'b0;
    total++;
    if (DONE !== 1'b1 || ERR !== 1'b0) begin
      bad++;
      $display("FAIL cksum_good: got done=%0b err=%0b, required 1 0", DONE, ERR);
    end
    do_reset();
    img[6] = 8'h05;
    foreach (img[i]) send_byte(img[i], 0);
    @(negedge CLK);
    BYTE_VALID = 1'b0;
    total++;
    if (DONE !== 1'b0 || ERR !== 1'b1 || CPU_HOLD !== 1'b1) begin
      bad++;
      $display("FAIL cksum_bad: got done=%0b err=%0b hold=%0b, required 0 1 1", DONE, ERR, CPU_HOLD);
    end
  endtask
`endif

  initial begin
    RST = 1'b1; BYTE_VALID = 1'b0; BYTE_IN = 8'h00;
    for (int i = 0; i < DEPTH; i++) begin
      written[i] = 1'b0;
      mem_model[i] = 32'd0;
    end
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_gaps();
    test_random();
    test_abort();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction loader that sits directly upstream of the MIPS core's instruction memory. It receives a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive word addresses of the instruction memory. It holds the core in reset until the image is fully written. This replaces the bench-only memory preload with a synthesizable load path.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction word width; fixed at 32, other values unsupported
- INSTR_MEM_DEPTH, 4096, instruction memory depth in words
- ADDR_WIDTH, $clog2(INSTR_MEM_DEPTH), word-address width

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous active-high reset
- BYTE_IN  in  8  incoming stream byte
- BYTE_VALID  in  1  BYTE_IN valid
- BYTE_READY  out  1  loader accepts byte this cycle
- MEM_WE  out  1  instruction memory write strobe, one cycle per word
- MEM_ADDR  out  ADDR_WIDTH  word address
- MEM_WDATA  out  32  assembled instruction word
- CPU_HOLD  out  1  high = core must be held in reset
- WORD_COUNT  out  16  words written so far
- DONE  out  1  image loaded; sticky until RST
- ERR  out  1  load failed; sticky until RST

## Operation
- Stream format: 2-byte word count N, MSB first. Then 4N payload bytes, each word MSB first. With the checksum macro, one checksum byte follows.
- A byte is accepted on a rising edge where BYTE_VALID && BYTE_READY.
- FSM states and transitions:
  - HDR: collect 2 count bytes. N==0 goes to DONE, or to CHK with the macro. N>INSTR_MEM_DEPTH goes to ERR. Otherwise go to PAYLOAD.
  - PAYLOAD: collect bytes with a 2-bit byte counter. On the 4th accepted byte, go to WRITE.
  - WRITE: MEM_WE=1 for exactly one cycle; WORD_COUNT increments. If WORD_COUNT==N after the increment, go to DONE (or CHK); otherwise return to PAYLOAD.
  - CHK (macro only): accept 1 byte. Go to DONE if it equals the XOR of all payload bytes, else go to ERR.
  - DONE, ERR: terminal states. BYTE_READY=0. Only RST leaves them.
- MEM_ADDR = WORD_COUNT[ADDR_WIDTH-1:0] during WRITE. The first word goes to address 0.
- CPU_HOLD is high in every state except DONE. ERR keeps the core held.
- BYTE_READY=1 only in HDR, PAYLOAD and CHK.
- A partial word is never written. A stalled stream (BYTE_VALID low) simply waits, with no timeout.
- Reset (RST high), asynchronous:
  - state returns to HDR
  - byte counter, WORD_COUNT, MEM_WE, DONE, ERR, MEM_ADDR and MEM_WDATA clear to 0
  - CPU_HOLD=1
  - BYTE_READY=0 while RST is asserted, and 1 from the first cycle after release
  - reset mid-load discards the partial image; memory contents are left as written

## Timing
- Word latency: the 4th byte is accepted at edge k. MEM_WE, MEM_ADDR and MEM_WDATA are valid in the cycle between edges k and k+1. The memory captures the word at edge k+1.
- BYTE_READY=0 during WRITE. Peak rate is 4 bytes per 5 cycles.
- DONE rises, and CPU_HOLD falls, in the cycle after the final WRITE (or after the CHK accept edge).
- All outputs are registered except BYTE_READY, which decodes from state.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - the CHK state exists
  - an 8-bit running XOR accumulates every payload byte (header excluded)
  - a mismatch sets ERR
- Undefined:
  - no CHK state and no XOR register
  - the stream ends after the last payload byte
  - ERR is set only by N>INSTR_MEM_DEPTH

## Structure
- Shared package mips_pkg holds:
  - the loader state enum (LD_HDR, LD_PAYLOAD, LD_WRITE, LD_CHK, LD_DONE, LD_ERR)
  - the constant LD_COUNT_BYTES=2
  - the DATA_WIDTH default
- One sub-module: ld_word_assembler, a byte shift register plus 2-bit counter with a word_full output. The FSM stays in instr_loader.

## Test plan
- Load N=2, bytes 00 02 20 10 00 05 02 11 40 20 -> two MEM_WE pulses: addr0=0x20100005, addr1=0x02114020. Then DONE=1 and CPU_HOLD=0.
- Header 00 00 -> no MEM_WE; DONE=1 one cycle after the second header byte (macro off).
- Header 10 01 (N=4097) with INSTR_MEM_DEPTH=4096 -> ERR=1, CPU_HOLD=1, BYTE_READY=0, no writes.
- Random BYTE_VALID gaps for N=3 -> same 3 words and addresses as the gap-free run. BYTE_READY is low exactly in WRITE cycles.
- RST pulse after 6 payload bytes of N=4, then a full reload with N=1 -> word 0 is rewritten, WORD_COUNT=1, DONE=1, and there is no write to address 1 from the aborted load.
- With LOADER_CHECKSUM_EN, N=1 with payload 01 02 03 04:
  - checksum 04 -> DONE=1
  - checksum 05 -> ERR=1
